mdu: RTL and testbench

- Multiply/divide unit in the EX stage, beside the ALU; takes the same SrcA/SrcB operands from the ID/EX pipeline register.
- Implements multi-cycle mult/multu/div/divu with architectural HI/LO registers, plus mthi/mtlo writes.
- Drives `busy` so the hazard unit can stall any MD-class instruction in D while an operation is in flight.
- mfhi/mflo read the HI/LO outputs combinationally.

---
 rtl/mdu.sv | 146 ++++++++++++++
 tb/tb_mdu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO
//            registers. Optional macro MDU_MADD_EN adds madd/maddu/msub/msubu.
// Revision : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0]  c_op_mult  = 4'd1;
    localparam logic [3:0]  c_op_multu = 4'd2;
    localparam logic [3:0]  c_op_div   = 4'd3;
    localparam logic [3:0]  c_op_divu  = 4'd4;
    localparam logic [3:0]  c_op_mthi  = 4'd5;
    localparam logic [3:0]  c_op_mtlo  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0]  c_op_madd  = 4'd7;
    localparam logic [3:0]  c_op_maddu = 4'd8;
    localparam logic [3:0]  c_op_msub  = 4'd9;
    localparam logic [3:0]  c_op_msubu = 4'd10;
`endif
    localparam logic [31:0] c_mult_cnt = 32'(MULT_CYCLES);
    localparam logic [31:0] c_div_cnt  = 32'(DIV_CYCLES);

    logic        r_busy;
    logic [31:0] r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_tmp;
    logic        r_wr;

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic        w_divz;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic        w_valid;
    logic        w_wr;
    logic [63:0] w_res;
    logic [31:0] w_load;
    logic        w_launch;

    // Low 64 bits of a 64x64 product of the extended operands are the exact result
    assign w_sprod = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
    assign w_uprod = {32'd0, SrcA} * {32'd0, SrcB};

    // Signed divide through magnitudes so 0x80000000 / -1 wraps cleanly
    assign w_divz   = (SrcB == 32'd0);
    assign w_a_mag  = SrcA[31] ? (32'd0 - SrcA) : SrcA;
    assign w_b_mag  = SrcB[31] ? (32'd0 - SrcB) : SrcB;
    assign w_sq_mag = w_a_mag / (w_divz ? 32'd1 : w_b_mag);
    assign w_sr_mag = w_a_mag % (w_divz ? 32'd1 : w_b_mag);
    assign w_sq     = (SrcA[31] ^ SrcB[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = SrcA[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
    assign w_uq     = SrcA / (w_divz ? 32'd1 : SrcB);
    assign w_ur     = SrcA % (w_divz ? 32'd1 : SrcB);

    always_comb begin
        w_valid = 1'b0;
        w_wr    = 1'b1;
        w_res   = 64'd0;
        w_load  = c_mult_cnt;
        case (op)
            c_op_mult:  begin w_valid = 1'b1; w_res = w_sprod; end
            c_op_multu: begin w_valid = 1'b1; w_res = w_uprod; end
            c_op_div: begin
                w_valid = 1'b1;
                w_res   = {w_sr, w_sq};
                w_wr    = ~w_divz;
                w_load  = c_div_cnt;
            end
            c_op_divu: begin
                w_valid = 1'b1;
                w_res   = {w_ur, w_uq};
                w_wr    = ~w_divz;
                w_load  = c_div_cnt;
            end
`ifdef MDU_MADD_EN
            c_op_madd:  begin w_valid = 1'b1; w_res = {r_hi, r_lo} + w_sprod; end
            c_op_maddu: begin w_valid = 1'b1; w_res = {r_hi, r_lo} + w_uprod; end
            c_op_msub:  begin w_valid = 1'b1; w_res = {r_hi, r_lo} - w_sprod; end
            c_op_msubu: begin w_valid = 1'b1; w_res = {r_hi, r_lo} - w_uprod; end
`endif
            default: ;
        endcase
    end

    assign w_launch = start & ~r_busy & w_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= 32'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_tmp  <= 64'd0;
            r_wr   <= 1'b0;
        end else if (r_busy) begin
            // Result is committed on the edge the counter reaches zero
            if (r_cnt <= 32'd1) begin
                r_busy <= 1'b0;
                r_cnt  <= 32'd0;
                if (r_wr) begin
                    r_hi <= r_tmp[63:32];
                    r_lo <= r_tmp[31:0];
                end
            end else begin
                r_cnt <= r_cnt - 32'd1;
            end
        end else if (w_launch) begin
            r_busy <= 1'b1;
            r_cnt  <= w_load;
            r_tmp  <= w_res;
            r_wr   <= w_wr;
        end else if (op == c_op_mthi) begin
            r_hi <= SrcA;
        end else if (op == c_op_mtlo) begin
            r_lo <= SrcA;
        end
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Purpose  : Self-checking bench for mdu against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .SrcA(a), .SrcB(b), .busy(busy), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    // Reference: applies one accepted operation to the model HI/LO, returns busy length
    task automatic model_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                            output int cyc);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, acc, p;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        acc = {m_hi, m_lo};
        cyc = 0;
        case (o)
            4'd1: begin cyc = MC; p = sx * sy; {m_hi, m_lo} = p; end
            4'd2: begin cyc = MC; p = ux * uy; {m_hi, m_lo} = p; end
            4'd3: begin
                cyc = DC;
                if (y != 0) begin
                    q = sx / sy; r = sx % sy;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            4'd4: begin
                cyc = DC;
                if (y != 0) begin
                    p = ux / uy; acc = ux % uy;
                    m_lo = p[31:0]; m_hi = acc[31:0];
                end
            end
            4'd5: m_hi = x;
            4'd6: m_lo = x;
            4'd7, 4'd8, 4'd9, 4'd10: begin
                if (MADD_EN) begin
                    cyc = MC;
                    if (o == 4'd7 || o == 4'd9) begin q = sx * sy; p = q; end
                    else p = ux * uy;
                    if (o <= 4'd8) acc = acc + p;
                    else           acc = acc - p;
                    {m_hi, m_lo} = acc;
                end
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic s, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        @(negedge clk);
        start = s; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 4'd0; a = $urandom; b = $urandom;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
    endtask

    task automatic test_basic;
        logic [3:0]  t_op [5] = '{4'd1, 4'd2, 4'd4, 4'd3, 4'd3};
        logic [31:0] t_a  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 32'h80000000};
        logic [31:0] t_b  [5] = '{32'd3, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFF};
        int cyc, n;
        for (int i = 0; i < 5; i++) begin
            model_op(t_op[i], t_a[i], t_b[i], cyc);
            drive(1'b1, t_op[i], t_a[i], t_b[i]);
            count_busy(n);
            n_vec++; if (n !== cyc) begin n_err++; $display("FAIL basic%0d_busy: got %0d want %0d", i, n, cyc); end
            n_vec++; if (hi !== m_hi) begin n_err++; $display("FAIL basic%0d_hi: got %h want %h", i, hi, m_hi); end
            n_vec++; if (lo !== m_lo) begin n_err++; $display("FAIL basic%0d_lo: got %h want %h", i, lo, m_lo); end
        end
    endtask

    task automatic test_divzero_ignore;
        int cyc, n;
        model_op(4'd5, 32'h1234, 32'd0, cyc);
        drive(1'b0, 4'd5, 32'h1234, 32'd0);
        n_vec++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi: got %h want 00001234", hi); end
        model_op(4'd4, 32'd7, 32'd0, cyc);
        drive(1'b1, 4'd4, 32'd7, 32'd0);
        n = (busy === 1'b1) ? 1 : 0;
        while (busy === 1'b1 && n < 200) begin
            if (n == 3)      begin start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4; end
            else if (n == 5) begin start = 1'b0; op = 4'd5; a = 32'hDEAD; end
            else             begin start = 1'b0; op = 4'd0; end
            @(negedge clk);
            if (hi !== m_hi) begin n_err++; $display("FAIL divz_hold_hi: got %h want %h", hi, m_hi); end
            if (busy === 1'b1) n++;
        end
        n_vec++;
        start = 1'b0; op = 4'd0;
        n_vec++; if (n !== cyc) begin n_err++; $display("FAIL divz_busy: got %0d want %0d", n, cyc); end
        repeat (MC + 2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignored_start_busy: got %b want 0", busy); end
        n_vec++; if (hi !== m_hi) begin n_err++; $display("FAIL divz_hi: got %h want %h", hi, m_hi); end
        n_vec++; if (lo !== m_lo) begin n_err++; $display("FAIL divz_lo: got %h want %h", lo, m_lo); end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 4'd1, 32'd3, 32'd4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL midreset_hi: got %h want 0", hi); end
        repeat (MC + 2) @(negedge clk);
        n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL midreset_lo_later: got %h want 0", lo); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy_later: got %b want 0", busy); end
    endtask

    task automatic test_madd;
        int cyc, n;
        model_op(4'd5, 32'd0, 32'd0, cyc);
        drive(1'b0, 4'd5, 32'd0, 32'd0);
        model_op(4'd6, 32'hFFFFFFFF, 32'd0, cyc);
        drive(1'b0, 4'd6, 32'hFFFFFFFF, 32'd0);
        model_op(4'd7, 32'd1, 32'd1, cyc);
        drive(1'b1, 4'd7, 32'd1, 32'd1);
        count_busy(n);
        n_vec++; if (n !== cyc) begin n_err++; $display("FAIL madd_busy: got %0d want %0d", n, cyc); end
        n_vec++; if (hi !== m_hi) begin n_err++; $display("FAIL madd_hi: got %h want %h", hi, m_hi); end
        n_vec++; if (lo !== m_lo) begin n_err++; $display("FAIL madd_lo: got %h want %h", lo, m_lo); end
    endtask

    task automatic test_random;
        int cyc, n;
        logic s;
        logic [3:0] o, mo;
        logic [31:0] x, y;
        for (int i = 0; i < 80; i++) begin
            o = 4'($urandom_range(0, 15));
            s = ($urandom_range(0, 3) != 0);
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if (o == 4'd3 && $urandom_range(0, 9) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            mo = (s || o == 4'd5 || o == 4'd6) ? o : 4'd0;
            model_op(mo, x, y, cyc);
            drive(s, o, x, y);
            count_busy(n);
            n_vec++; if (n !== cyc) begin n_err++; $display("FAIL rnd%0d_busy op=%0d: got %0d want %0d", i, o, n, cyc); end
            n_vec++; if (hi !== m_hi) begin n_err++; $display("FAIL rnd%0d_hi op=%0d: got %h want %h", i, o, hi, m_hi); end
            n_vec++; if (lo !== m_lo) begin n_err++; $display("FAIL rnd%0d_lo op=%0d: got %h want %h", i, o, lo, m_lo); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_divzero_ignore;
        test_reset_mid;
        test_madd;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
